// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - single-transaction I2C master (START, addr+R/W, one data byte, STOP)
//
// Ports:
//   clk, rst_n                       system clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_addr, cmd_rw, cmd_wdata      7-bit target, 0=write/1=read, write byte
//   rsp_valid                        one-cycle pulse at transaction end
//   rsp_rdata, rsp_nack              read byte and NACK flag, held between commands
//   busy                             accept through rsp_valid cycle inclusive
//   scl, sda                         open-drain bus lines (drive 0 or release)
//
// Build option: I2C_CLOCK_STRETCH_EN - quarter timer waits for the scl line to
// read high after the master releases it.

module i2c_master_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   inout  wire        scl,
   inout  wire        sda
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_START    = 4'd1;
   localparam logic [3:0] S_ADDR     = 4'd2;
   localparam logic [3:0] S_ADDR_ACK = 4'd3;
   localparam logic [3:0] S_WDATA    = 4'd4;
   localparam logic [3:0] S_WACK     = 4'd5;
   localparam logic [3:0] S_RDATA    = 4'd6;
   localparam logic [3:0] S_RNACK    = 4'd7;
   localparam logic [3:0] S_STOP     = 4'd8;
   localparam logic [3:0] S_DONE     = 4'd9;

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

   logic [3:0]    state;
   logic [QW-1:0] qcnt;
   logic [1:0]    quarter;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          rw_q;
   logic [7:0]    wdata_q;
   logic          ack_bit;

   logic scl_low;
   logic sda_low;
   logic in_phase;
   logic stall;
   logic tick;
   logic sample_now;
   logic phase_end;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_DONE);

   assign scl = scl_low ? 1'b0 : 1'bz;
   assign sda = sda_low ? 1'b0 : 1'bz;

   // Line levels are a pure function of state/quarter, so a reset releases
   // both lines on the very edge it is sampled.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state)
         S_START: begin
            sda_low = quarter[1];
            scl_low = (quarter == 2'd3);
         end
         S_ADDR, S_WDATA: begin
            scl_low = ~quarter[1];
            sda_low = ~shift[7];
         end
         S_ADDR_ACK, S_WACK, S_RDATA, S_RNACK: begin
            scl_low = ~quarter[1];
         end
         S_STOP: begin
            scl_low = (quarter == 2'd0);
            sda_low = ~quarter[1];
         end
         default: ;
      endcase
   end

   assign in_phase = (state != S_IDLE) && (state != S_DONE);

`ifdef I2C_CLOCK_STRETCH_EN
   // A slave holding scl low after release freezes the quarter timer.
   assign stall = !scl_low && (scl == 1'b0) &&
                  ((state == S_STOP) ? (quarter == 2'd1) : (quarter == 2'd2));
`else
   assign stall = 1'b0;
`endif

   assign tick       = in_phase && (qcnt == Q_LAST) && !stall;
   assign sample_now = tick && (quarter == 2'd2);
   assign phase_end  = tick && (quarter == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         qcnt      <= '0;
         quarter   <= 2'd0;
         bit_cnt   <= 3'd0;
         shift     <= 8'd0;
         rw_q      <= 1'b0;
         wdata_q   <= 8'd0;
         ack_bit   <= 1'b0;
         rsp_rdata <= 8'd0;
         rsp_nack  <= 1'b0;
      end else begin
         if (in_phase) begin
            if (tick) begin
               qcnt    <= '0;
               quarter <= quarter + 2'd1;
            end else if (!stall) begin
               qcnt <= qcnt + 1'b1;
            end
         end

         if (sample_now) begin
            ack_bit <= sda;
            if (state == S_RDATA)
               shift <= {shift[6:0], sda};
         end

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  state    <= S_START;
                  shift    <= {cmd_addr, cmd_rw};
                  rw_q     <= cmd_rw;
                  wdata_q  <= cmd_wdata;
                  rsp_nack <= 1'b0;
                  qcnt     <= '0;
                  quarter  <= 2'd0;
               end
            end
            S_START: begin
               if (phase_end) begin
                  state   <= S_ADDR;
                  bit_cnt <= 3'd7;
               end
            end
            S_ADDR, S_WDATA: begin
               if (phase_end) begin
                  if (bit_cnt == 3'd0) begin
                     state <= (state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                  end else begin
                     bit_cnt <= bit_cnt - 3'd1;
                     shift   <= {shift[6:0], 1'b0};
                  end
               end
            end
            S_ADDR_ACK: begin
               if (phase_end) begin
                  if (ack_bit) begin
                     rsp_nack <= 1'b1;
                     state    <= S_STOP;
                  end else if (rw_q) begin
                     state   <= S_RDATA;
                     bit_cnt <= 3'd7;
                  end else begin
                     state   <= S_WDATA;
                     shift   <= wdata_q;
                     bit_cnt <= 3'd7;
                  end
               end
            end
            S_WACK: begin
               if (phase_end) begin
                  if (ack_bit)
                     rsp_nack <= 1'b1;
                  state <= S_STOP;
               end
            end
            S_RDATA: begin
               // rsp_rdata only changes once the full byte is in, so an
               // aborted read never exposes partial bits.
               if (phase_end) begin
                  if (bit_cnt == 3'd0) begin
                     rsp_rdata <= shift;
                     state     <= S_RNACK;
                  end else begin
                     bit_cnt <= bit_cnt - 3'd1;
                  end
               end
            end
            S_RNACK: begin
               if (phase_end)
                  state <= S_STOP;
            end
            S_STOP: begin
               if (phase_end)
                  state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed self-checking bench for i2c_master_ctrl with a bus slave model
`timescale 1ns/1ps

module tb_i2c_master_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic       cmd_rw;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       busy;
   wire        scl;
   wire        sda;

   pullup (scl);
   pullup (sda);

   logic tb_scl_hold = 1'b0;
   assign scl = tb_scl_hold ? 1'b0 : 1'bz;

   i2c_master_ctrl #(.CLK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_rw    (cmd_rw),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_nack  (rsp_nack),
      .busy      (busy),
      .scl       (scl),
      .sda       (sda)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Slave at 0x14, returns 0x9C on reads; samples the bus once per clk.
   logic       bus_scl;
   logic       bus_sda;
   assign bus_scl = scl;
   assign bus_sda = sda;

   logic       s_prev_scl = 1'b1;
   logic       s_prev_sda = 1'b1;
   int         s_state    = 0;
   int         s_cnt      = 0;
   logic [7:0] s_shift    = 8'd0;
   logic       s_rw       = 1'b0;
   logic       s_drive    = 1'b0;
   logic [7:0] s_data     = 8'd0;
   int         s_writes   = 0;
   int         s_stops    = 0;
   int         s_rd_viol  = 0;
   logic [7:0] s_tx       = 8'h9C;

   assign sda = s_drive ? 1'b0 : 1'bz;

   always @(negedge clk) begin
      s_prev_scl <= bus_scl;
      s_prev_sda <= bus_sda;
      if ((s_state == 5 || s_state == 6) && bus_scl && !bus_sda && !s_drive)
         s_rd_viol <= s_rd_viol + 1;
      if (s_prev_scl && bus_scl && s_prev_sda && !bus_sda) begin
         s_state <= 1;
         s_cnt   <= 0;
         s_drive <= 1'b0;
      end else if (s_prev_scl && bus_scl && !s_prev_sda && bus_sda) begin
         s_state <= 0;
         s_drive <= 1'b0;
         s_stops <= s_stops + 1;
      end else if (!s_prev_scl && bus_scl) begin
         if (s_state == 1 || s_state == 3) begin
            s_shift <= {s_shift[6:0], bus_sda};
            s_cnt   <= s_cnt + 1;
         end
      end else if (s_prev_scl && !bus_scl) begin
         case (s_state)
            1: if (s_cnt == 8) begin
                  if (s_shift[7:1] == 7'h14) begin
                     s_drive <= 1'b1;
                     s_rw    <= s_shift[0];
                     s_state <= 2;
                  end else begin
                     s_state <= 7;
                  end
               end
            2: begin
                  s_cnt <= 0;
                  if (s_rw) begin
                     s_state <= 5;
                     s_drive <= ~s_tx[7];
                  end else begin
                     s_state <= 3;
                     s_drive <= 1'b0;
                  end
               end
            3: if (s_cnt == 8) begin
                  s_data   <= s_shift;
                  s_writes <= s_writes + 1;
                  s_drive  <= 1'b1;
                  s_state  <= 4;
               end
            4: begin
                  s_drive <= 1'b0;
                  s_state <= 7;
               end
            5: if (s_cnt == 7) begin
                  s_drive <= 1'b0;
                  s_state <= 6;
               end else begin
                  s_drive <= ~s_tx[6 - s_cnt];
                  s_cnt   <= s_cnt + 1;
               end
            6: s_state <= 7;
            default: ;
         endcase
      end
   end

   // Issue one command; lat = cycle offset of rsp_valid from the accept cycle
   // (accept cycle T, START at T+1). Returns at the negedge of the rsp_valid cycle.
   task automatic do_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd, output int lat);
      @(negedge clk);
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = ~a;
      cmd_rw    = ~rw;
      cmd_wdata = ~wd;
      lat = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
      if (lat < 0) begin
         n_checks++;
         $display("FAIL cmd_timeout: no rsp_valid within 2000 cycles (addr %h)", a);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = 7'h00;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b0) $display("FAIL reset_rsp_nack: got %b want 0", rsp_nack); else n_pass++;
      n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); else n_pass++;
      n_checks++; if (scl !== 1'b1) $display("FAIL reset_scl: got %b want 1 (released)", scl); else n_pass++;
      n_checks++; if (sda !== 1'b1) $display("FAIL reset_sda: got %b want 1 (released)", sda); else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write();
      int lat;
      int stops0;
      stops0 = s_stops;
      do_cmd(7'h14, 1'b0, 8'hA5, lat);
      n_checks++; if (lat != 321) $display("FAIL write_latency: got %0d want 321", lat); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b0) $display("FAIL write_nack: got %b want 0", rsp_nack); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL write_busy_in_done: got %b want 1", busy); else n_pass++;
      n_checks++; if (s_data !== 8'hA5) $display("FAIL write_slave_data: got %h want a5", s_data); else n_pass++;
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL write_rsp_pulse: got %b want 0", rsp_valid); else n_pass++;
      n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL write_idle: ready %b busy %b want 1 0", cmd_ready, busy); else n_pass++;
      n_checks++; if (s_stops != stops0 + 1) $display("FAIL write_stop: got %0d stops want %0d", s_stops, stops0 + 1); else n_pass++;
   endtask

   task automatic test_read();
      int lat;
      do_cmd(7'h14, 1'b1, 8'h00, lat);
      n_checks++; if (lat != 321) $display("FAIL read_latency: got %0d want 321", lat); else n_pass++;
      n_checks++; if (rsp_rdata !== 8'h9C) $display("FAIL read_data: got %h want 9c", rsp_rdata); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b0) $display("FAIL read_nack: got %b want 0", rsp_nack); else n_pass++;
      n_checks++; if (s_rd_viol != 0) $display("FAIL read_sda_driven: got %0d low cycles want 0", s_rd_viol); else n_pass++;
      @(negedge clk);
      n_checks++; if (rsp_rdata !== 8'h9C) $display("FAIL read_data_hold: got %h want 9c", rsp_rdata); else n_pass++;
   endtask

   task automatic test_addr_nack();
      int lat;
      int writes0;
      int stops0;
      writes0 = s_writes;
      stops0  = s_stops;
      do_cmd(7'h15, 1'b0, 8'h5A, lat);
      n_checks++; if (lat != 177) $display("FAIL nack_latency: got %0d want 177", lat); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b1) $display("FAIL nack_flag: got %b want 1", rsp_nack); else n_pass++;
      n_checks++; if (s_writes != writes0) $display("FAIL nack_no_data: got %0d bytes want %0d", s_writes, writes0); else n_pass++;
      n_checks++; if (rsp_rdata !== 8'h9C) $display("FAIL nack_rdata_hold: got %h want 9c", rsp_rdata); else n_pass++;
      @(negedge clk);
      n_checks++; if (s_stops != stops0 + 1) $display("FAIL nack_stop: got %0d stops want %0d", s_stops, stops0 + 1); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b1) $display("FAIL nack_flag_hold: got %b want 1", rsp_nack); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n_acc;
      int n_rsp;
      int a1;
      int a2;
      int r1;
      logic [7:0] d1;
      logic       nk1;
      n_acc = 0; n_rsp = 0; a1 = -1; a2 = -1; r1 = -1; d1 = 8'h00; nk1 = 1'bx;
      @(negedge clk);
      cmd_addr  = 7'h14;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h11;
      cmd_valid = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         if (cmd_valid && cmd_ready) begin
            n_acc++;
            if (n_acc == 1) a1 = k;
            else if (n_acc == 2) a2 = k;
         end
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (n_rsp == 1) begin
               r1  = k;
               d1  = s_data;
               nk1 = rsp_nack;
            end
         end
         if (n_rsp == 2) break;
         @(posedge clk);
         #1;
         if (n_acc == 1) cmd_wdata = 8'h22;
         if (n_acc >= 2) cmd_valid = 1'b0;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      n_checks++; if (n_rsp != 2) $display("FAIL b2b_timeout: got %0d responses want 2", n_rsp); else n_pass++;
      n_checks++; if (r1 - a1 != 321) $display("FAIL b2b_first_latency: got %0d want 321", r1 - a1); else n_pass++;
      n_checks++; if (a2 - r1 != 1) $display("FAIL b2b_second_accept: got %0d cycles after rsp want 1", a2 - r1); else n_pass++;
      n_checks++; if (n_acc != 2) $display("FAIL b2b_accept_count: got %0d want 2", n_acc); else n_pass++;
      n_checks++; if (d1 !== 8'h11) $display("FAIL b2b_first_data: got %h want 11", d1); else n_pass++;
      n_checks++; if (nk1 !== 1'b0) $display("FAIL b2b_nack_cleared: got %b want 0", nk1); else n_pass++;
      n_checks++; if (s_data !== 8'h22) $display("FAIL b2b_second_data: got %h want 22", s_data); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat;
      int spurious;
      @(negedge clk);
      cmd_addr  = 7'h14;
      cmd_rw    = 1'b0;
      cmd_wdata = 8'h77;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      // Cycle T+84 lies inside the fifth address phase (address bit 3).
      repeat (83) @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else n_pass++;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (scl !== 1'b1 || sda !== 1'b1) $display("FAIL rstmid_lines: scl %b sda %b want 1 1", scl, sda); else n_pass++;
      n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rstmid_idle: busy %b ready %b want 0 1", busy, cmd_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) spurious++;
      end
      n_checks++; if (spurious != 0) $display("FAIL rstmid_no_rsp: got %0d rsp_valid cycles want 0", spurious); else n_pass++;
      do_cmd(7'h14, 1'b0, 8'h3C, lat);
      n_checks++; if (lat != 321) $display("FAIL rstmid_latency: got %0d want 321", lat); else n_pass++;
      n_checks++; if (s_data !== 8'h3C) $display("FAIL rstmid_data: got %h want 3c", s_data); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b0) $display("FAIL rstmid_nack: got %b want 0", rsp_nack); else n_pass++;
      @(negedge clk);
   endtask

`ifdef I2C_CLOCK_STRETCH_EN
   task automatic test_stretch();
      int lat;
      fork
         do_cmd(7'h14, 1'b0, 8'h5A, lat);
         begin
            @(negedge clk);
            @(posedge clk);
            // Cycle T+25 is Q2 of the first address bit.
            repeat (24) @(posedge clk);
            #1 tb_scl_hold = 1'b1;
            repeat (10) @(posedge clk);
            #1 tb_scl_hold = 1'b0;
         end
      join
      n_checks++; if (lat != 331) $display("FAIL stretch_latency: got %0d want 331", lat); else n_pass++;
      n_checks++; if (s_data !== 8'h5A) $display("FAIL stretch_data: got %h want 5a", s_data); else n_pass++;
      n_checks++; if (rsp_nack !== 1'b0) $display("FAIL stretch_nack: got %b want 0", rsp_nack); else n_pass++;
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_addr_nack();
      test_back_to_back();
      test_reset_mid();
`ifdef I2C_CLOCK_STRETCH_EN
      test_stretch();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Single-clock I2C master that sequences one complete bus transaction per command: START, 7-bit address plus R/W, address ACK check, one data byte (write or read), then STOP. It drives the open-drain `scl` and `sda` lines of the shared bus to which the team's `i2cs` slaves attach. Host logic issues commands over a valid/ready handshake and receives a one-cycle response pulse.

Parameters:
CLK_DIV, 4, `clk` cycles per SCL quarter-period (>=1); one SCL bit = 4*CLK_DIV cycles.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_addr  input  7  target slave address
cmd_rw  input  1  0 = write byte, 1 = read byte
cmd_wdata  input  8  byte to write
rsp_valid  output  1  one-cycle pulse at transaction end
rsp_rdata  output  8  byte read (held until next read completes)
rsp_nack  output  1  address or data NACK seen (valid with rsp_valid, held)
busy  output  1  high from accept until rsp_valid cycle inclusive
scl  inout  1  open-drain: drives 0 or 'z'
sda  inout  1  open-drain: drives 0 or 'z'

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; scl/sda released ('z'); cmd_ready=1; busy=0; rsp_valid=0; rsp_nack=0; rsp_rdata=0; quarter counter=0.
- Reset mid-transaction: lines released on that edge, no STOP generated, no rsp_valid; any partially assembled rsp_rdata bits discarded.
- Accept: cmd fields latched on the accept edge; the shift byte is {cmd_addr, cmd_rw}. Inputs are ignored afterwards.
- Quarter timer: each quarter lasts CLK_DIV cycles. Every phase below consists of 4 quarters Q0..Q3.
- Bit phase:
  - Q0/Q1: SCL low; SDA updated at start of Q0.
  - Q2/Q3: SCL released; `sda` sampled on the last cycle of Q2.
- States:
  - IDLE: cmd_ready=1.
  - START: Q0-Q1 both released; Q2 SDA low with SCL high (START); Q3 SCL low.
  - ADDR: 8 bits, MSB first.
  - ADDR_ACK: SDA released; sample 0 = ACK; 1 -> rsp_nack=1 and go to STOP.
  - WDATA (rw=0): 8 bits of cmd_wdata, MSB first.
  - WACK: sample slave ACK; 1 -> rsp_nack=1.
  - RDATA (rw=1): SDA released; 8 samples shifted in MSB first.
  - RNACK: master releases SDA (NACK, single-byte read).
  - STOP: Q0 SDA low/SCL low; Q1 SCL released; Q2 SDA released while SCL high (STOP); Q3 idle.
  - DONE: rsp_valid=1 for one cycle, then IDLE.
- Latency, no NACK: accept at cycle T; START begins T+1; 20 phases = 80 quarters; rsp_valid at T+1+80*CLK_DIV. For CLK_DIV=4: T+321.
- Latency, address NACK: 11 phases; rsp_valid at T+1+44*CLK_DIV.
- rsp_nack cleared on each accept.
- Back-to-back commands: cmd_ready is 0 during DONE, so the earliest next accept is the cycle after rsp_valid.
- cmd_valid while busy is ignored and not queued.
- A read never drives SDA low during RDATA or RNACK.

Optional Feature:
Macro I2C_CLOCK_STRETCH_EN.
- Defined: on entering Q2 (and STOP Q1) after releasing SCL, the quarter timer holds until the `scl` input reads 1. Stretch cycles add to latency; all other timing is unchanged.
- Undefined: SCL is not read back; timing is purely counter-driven and latency is exactly as stated above.

Test Plan:
1. CLK_DIV=4, pull-ups, `i2cs` at 0x14; write addr=0x14 data=0xA5 -> rsp_valid at T+321, rsp_nack=0, slave data_in=0xA5.
2. Read addr=0x14 -> rsp_valid at T+321, rsp_rdata=0x9C, rsp_nack=0, master SDA never driven low in RDATA.
3. Write addr=0x15 (no slave) -> rsp_nack=1, rsp_valid at T+177, no data phase, STOP seen on bus.
4. Assert rst_n=0 during bit 3 of ADDR -> next edge scl=sda='z', busy=0, cmd_ready=1, no rsp_valid; a new write of 0x3C then completes normally.
5. Hold cmd_valid continuously with 2 commands -> second accept exactly 1 cycle after first rsp_valid; cmd_valid pulses while busy are ignored.
6. With I2C_CLOCK_STRETCH_EN, bench holds scl low 10 cycles at the first address bit -> rsp_valid at T+331, data correct.
